// File: rtl/pipe_issue_ctrl.sv
// Run-control and hazard sequencer for a 3-stage pipeline: gates PC advance and
// decode-to-execute issue, tracks in-flight register writes, and sequences start/stop/step with drain.
module pipe_issue_ctrl #(
    parameter  int NREG      = 16,
    parameter  int DRAIN_MAX = 8,
    parameter  int CNT_W     = 16,
    localparam int AW        = $clog2(NREG)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_step,
    input  logic             i_dec_valid,
    input  logic [AW-1:0]    i_dec_srcadd_1,
    input  logic [AW-1:0]    i_dec_srcadd_2,
    input  logic [AW-1:0]    i_dec_destadd,
    input  logic             i_dec_wr,
    input  logic             i_dec_halt,
    input  logic             i_wb_en,
    input  logic [AW-1:0]    i_wb_add,
    output logic             o_fetch_en,
    output logic             o_issue,
    output logic             o_bubble,
    output logic [2:0]       o_state,
    output logic             o_busy,
    output logic             o_drain_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int TW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [NREG-1:0]  pend_reg, pend_next;
    logic             halt_flag_reg, halt_flag_next;
    logic             drain_err_reg, drain_err_next;
    logic [TW-1:0]    drain_timer_reg, drain_timer_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic active;
    logic hazard;
    logic issue;
    logic drain_timeout;

    // Hazard looks only at the registered scoreboard, so a same-cycle write-back still stalls once.
    assign active = (state_reg == S_RUN) || (state_reg == S_STEP);
    assign hazard = i_dec_valid & (pend_reg[i_dec_srcadd_1] | pend_reg[i_dec_srcadd_2] |
                                   (i_dec_wr & pend_reg[i_dec_destadd]));
    assign issue  = active & i_dec_valid & ~hazard;

    assign drain_timeout = (state_reg == S_DRAIN) && (pend_reg != '0) &&
                           (drain_timer_reg == DRAIN_LAST);

    // Per-register pending bit: a new issue's set beats a same-cycle write-back clear.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue & i_dec_wr & ~i_dec_halt & (i_dec_destadd == AW'(gi));
            assign clr_bit = i_wb_en & (i_wb_add == AW'(gi));
            assign pend_next[gi] = ~drain_timeout & (set_bit | (pend_reg[gi] & ~clr_bit));
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        halt_flag_next   = halt_flag_reg;
        drain_err_next   = drain_err_reg;
        drain_timer_next = '0;
        stall_cnt_next   = stall_cnt_reg;

        if (active && hazard && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_RUN;
                end else if (i_step) begin
                    state_next = S_STEP;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    state_next     = S_DRAIN;
                    halt_flag_next = 1'b0;
                end else if (issue && i_dec_halt) begin
                    state_next     = S_DRAIN;
                    halt_flag_next = 1'b1;
                end
            end
            S_STEP: begin
                if (i_stop) begin
                    state_next     = S_DRAIN;
                    halt_flag_next = 1'b0;
                end else if (issue) begin
                    state_next     = S_DRAIN;
                    halt_flag_next = i_dec_halt;
                end
            end
            S_DRAIN: begin
                if (pend_reg == '0) begin
                    state_next = halt_flag_reg ? S_HALTED : S_IDLE;
                end else if (drain_timeout) begin
                    drain_err_next = 1'b1;
                    state_next     = S_IDLE;
                end else begin
                    drain_timer_next = drain_timer_reg + 1'b1;
                end
            end
            S_HALTED: begin
                if (i_start) begin
                    state_next     = S_RUN;
                    halt_flag_next = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= S_IDLE;
            pend_reg        <= '0;
            halt_flag_reg   <= 1'b0;
            drain_err_reg   <= 1'b0;
            drain_timer_reg <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            pend_reg        <= pend_next;
            halt_flag_reg   <= halt_flag_next;
            drain_err_reg   <= drain_err_next;
            drain_timer_reg <= drain_timer_next;
            stall_cnt_reg   <= stall_cnt_next;
        end
    end

    assign o_issue     = issue;
    assign o_bubble    = active & hazard;
    assign o_fetch_en  = active & ~hazard & ~(i_dec_valid & i_dec_halt);
    assign o_state     = state_reg;
    assign o_busy      = (state_reg != S_IDLE) && (state_reg != S_HALTED);
    assign o_drain_err = drain_err_reg;
    assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed vector table, hand sequences for reset,
// and a randomized run against a rule-level reference model.
module tb_pipe_issue_ctrl;
    localparam int NREG      = 16;
    localparam int DRAIN_MAX = 8;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             i_reset, i_start, i_stop, i_step, i_dec_valid;
    logic [3:0]       i_dec_srcadd_1, i_dec_srcadd_2, i_dec_destadd, i_wb_add;
    logic             i_dec_wr, i_dec_halt, i_wb_en;
    logic             o_fetch_en, o_issue, o_bubble, o_busy, o_drain_err;
    logic [2:0]       o_state;
    logic [CNT_W-1:0] o_stall_cnt;

    always #5 clk = ~clk;

    pipe_issue_ctrl #(.NREG(NREG), .DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop), .i_step(i_step),
        .i_dec_valid(i_dec_valid), .i_dec_srcadd_1(i_dec_srcadd_1), .i_dec_srcadd_2(i_dec_srcadd_2),
        .i_dec_destadd(i_dec_destadd), .i_dec_wr(i_dec_wr), .i_dec_halt(i_dec_halt),
        .i_wb_en(i_wb_en), .i_wb_add(i_wb_add),
        .o_fetch_en(o_fetch_en), .o_issue(o_issue), .o_bubble(o_bubble), .o_state(o_state),
        .o_busy(o_busy), .o_drain_err(o_drain_err), .o_stall_cnt(o_stall_cnt)
    );

    typedef struct packed {
        logic       start, stop, step, dv;
        logic [3:0] s1, s2, d;
        logic       wr, halt, wbe;
        logic [3:0] wba;
    } in_t;

    typedef struct packed {
        logic             fetch, issue, bubble;
        logic [2:0]       state;
        logic             busy, err;
        logic [CNT_W-1:0] stall;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];

    // Reference model state
    int   m_state;
    bit   m_pend[NREG];
    bit   m_hf, m_err;
    int   m_timer, m_stall;

    function automatic vec_t mkv(input int st, sp, sg, dv, s1, s2, d, wr, hl, we, wa,
                                 ef, ei, eb, es, ebs, eer, esc);
        vec_t v;
        v.in.start = st[0];  v.in.stop = sp[0];  v.in.step = sg[0];  v.in.dv = dv[0];
        v.in.s1 = s1[3:0];   v.in.s2 = s2[3:0];  v.in.d = d[3:0];
        v.in.wr = wr[0];     v.in.halt = hl[0];  v.in.wbe = we[0];   v.in.wba = wa[3:0];
        v.exp.fetch = ef[0]; v.exp.issue = ei[0]; v.exp.bubble = eb[0];
        v.exp.state = es[2:0]; v.exp.busy = ebs[0]; v.exp.err = eer[0];
        v.exp.stall = esc[CNT_W-1:0];
        return v;
    endfunction

    task automatic drive(input in_t x);
        i_start = x.start; i_stop = x.stop; i_step = x.step; i_dec_valid = x.dv;
        i_dec_srcadd_1 = x.s1; i_dec_srcadd_2 = x.s2; i_dec_destadd = x.d;
        i_dec_wr = x.wr; i_dec_halt = x.halt; i_wb_en = x.wbe; i_wb_add = x.wba;
    endtask

    function automatic out_t sample();
        return {o_fetch_en, o_issue, o_bubble, o_state, o_busy, o_drain_err, o_stall_cnt};
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got fib=%b%b%b st=%0d busy=%b err=%b stall=%0d want fib=%b%b%b st=%0d busy=%b err=%b stall=%0d",
                     name, act.fetch, act.issue, act.bubble, act.state, act.busy, act.err, act.stall,
                     exp.fetch, exp.issue, exp.bubble, exp.state, exp.busy, exp.err, exp.stall);
        end
    endtask

    function automatic out_t model_out(input in_t x);
        out_t o;
        bit   haz, run;
        haz = x.dv && (m_pend[x.s1] || m_pend[x.s2] || (x.wr && m_pend[x.d]));
        run = (m_state == 1) || (m_state == 2);
        o.fetch  = run && !haz && !(x.dv && x.halt);
        o.issue  = run && x.dv && !haz;
        o.bubble = run && haz;
        o.state  = m_state[2:0];
        o.busy   = (m_state != 0) && (m_state != 4);
        o.err    = m_err;
        o.stall  = m_stall[CNT_W-1:0];
        return o;
    endfunction

    task automatic model_step(input in_t x, input bit rst);
        bit haz, run, iss, any;
        bit np[NREG];
        int nstate;
        if (rst) begin
            m_state = 0; m_hf = 0; m_err = 0; m_timer = 0; m_stall = 0;
            foreach (m_pend[k]) m_pend[k] = 0;
        end else begin
            haz = x.dv && (m_pend[x.s1] || m_pend[x.s2] || (x.wr && m_pend[x.d]));
            run = (m_state == 1) || (m_state == 2);
            iss = run && x.dv && !haz;
            if (run && haz && m_stall < (1 << CNT_W) - 1) m_stall++;
            np = m_pend;
            if (x.wbe) np[x.wba] = 0;
            if (iss && x.wr && !x.halt) np[x.d] = 1;
            any = 0;
            foreach (m_pend[k]) any |= m_pend[k];
            nstate = m_state;
            case (m_state)
                0: if (x.start) nstate = 1; else if (x.step) nstate = 2;
                1: if (x.stop) begin nstate = 3; m_hf = 0; end
                   else if (iss && x.halt) begin nstate = 3; m_hf = 1; end
                2: if (x.stop) begin nstate = 3; m_hf = 0; end
                   else if (iss) begin nstate = 3; m_hf = x.halt; end
                3: if (!any) nstate = m_hf ? 4 : 0;
                   else if (m_timer == DRAIN_MAX - 1) begin
                       m_err = 1; nstate = 0;
                       foreach (np[k]) np[k] = 0;
                   end else m_timer++;
                4: if (x.start) begin nstate = 1; m_hf = 0; end
                default: nstate = 0;
            endcase
            if (nstate == 3 && m_state != 3) m_timer = 0;
            m_pend  = np;
            m_state = nstate;
        end
    endtask

    function automatic in_t rand_in();
        in_t r;
        int  q[$];
        r.start = ($urandom_range(19) == 0);
        r.stop  = ($urandom_range(29) == 0);
        r.step  = ($urandom_range(19) == 0);
        r.dv    = ($urandom_range(3) != 0);
        r.s1    = 4'($urandom_range(7));
        r.s2    = 4'($urandom_range(7));
        r.d     = 4'($urandom_range(15));
        r.wr    = ($urandom_range(3) != 0);
        r.halt  = ($urandom_range(24) == 0);
        r.wbe   = ($urandom_range(1) == 0);
        foreach (m_pend[k]) if (m_pend[k]) q.push_back(k);
        if (q.size() > 0 && $urandom_range(3) != 0)
            r.wba = 4'(q[$urandom_range(q.size() - 1)]);
        else
            r.wba = 4'($urandom_range(15));
        return r;
    endfunction

    initial begin
        in_t  z, x;
        out_t zo;
        bit   rst;
        z = '0; zo = '0;

        //          st sp sg dv s1 s2 d  wr hl we wa  f  i  b  st bs er stall
        tbl.push_back(mkv(1,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mkv(0,0,0, 1,8,9,1,1,0, 0,0, 1,1,0,1,1,0,0));
        tbl.push_back(mkv(0,0,0, 1,10,11,2,1,0, 0,0, 1,1,0,1,1,0,0));
        tbl.push_back(mkv(0,0,0, 1,12,13,3,1,0, 0,0, 1,1,0,1,1,0,0));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 1,1, 1,0,0,1,1,0,0));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 1,2, 1,0,0,1,1,0,0));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 1,3, 1,0,0,1,1,0,0));
        // RAW on r5: three bubbles, the last coinciding with its write-back
        tbl.push_back(mkv(0,0,0, 1,1,2,5,1,0, 0,0, 1,1,0,1,1,0,0));
        tbl.push_back(mkv(0,0,0, 1,5,0,6,1,0, 0,0, 0,0,1,1,1,0,0));
        tbl.push_back(mkv(0,0,0, 1,5,0,6,1,0, 0,0, 0,0,1,1,1,0,1));
        tbl.push_back(mkv(0,0,0, 1,5,0,6,1,0, 1,5, 0,0,1,1,1,0,2));
        tbl.push_back(mkv(0,0,0, 1,5,0,6,1,0, 0,0, 1,1,0,1,1,0,3));
        // Set of r7 and write-back of r7 in the same cycle: the set survives
        tbl.push_back(mkv(0,0,0, 1,0,0,7,1,0, 1,7, 1,1,0,1,1,0,3));
        tbl.push_back(mkv(0,0,0, 1,7,0,8,1,0, 1,6, 0,0,1,1,1,0,3));
        tbl.push_back(mkv(0,0,0, 1,7,0,8,1,0, 1,7, 0,0,1,1,1,0,4));
        tbl.push_back(mkv(0,0,0, 1,7,0,8,1,0, 0,0, 1,1,0,1,1,0,5));
        // HALT (with wr set, which must not mark r9) while r8 is pending
        tbl.push_back(mkv(0,0,0, 1,0,0,9,1,1, 0,0, 0,1,0,1,1,0,5));
        tbl.push_back(mkv(1,0,0, 1,0,0,0,0,0, 0,0, 0,0,0,3,1,0,5));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 1,8, 0,0,0,3,1,0,5));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,3,1,0,5));
        tbl.push_back(mkv(0,1,1, 0,0,0,0,0,0, 0,0, 0,0,0,4,0,0,5));
        tbl.push_back(mkv(1,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,4,0,0,5));
        tbl.push_back(mkv(0,1,0, 0,0,0,0,0,0, 0,0, 1,0,0,1,1,0,5));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,3,1,0,5));
        // Single step: wait with no valid instruction, then one issue, drain, idle
        tbl.push_back(mkv(0,1,1, 0,0,0,0,0,0, 0,0, 0,0,0,0,0,0,5));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 0,0, 1,0,0,2,1,0,5));
        tbl.push_back(mkv(0,0,0, 1,0,0,4,1,0, 0,0, 1,1,0,2,1,0,5));
        tbl.push_back(mkv(0,0,1, 0,0,0,0,0,0, 1,4, 0,0,0,3,1,0,5));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,3,1,0,5));
        tbl.push_back(mkv(0,0,1, 0,0,0,0,0,0, 0,0, 0,0,0,0,0,0,5));
        tbl.push_back(mkv(0,0,0, 1,0,0,0,0,1, 0,0, 0,1,0,2,1,0,5));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,3,1,0,5));
        tbl.push_back(mkv(1,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,4,0,0,5));
        // Stop with r3 pending and no write-back: drain times out after 8 cycles
        tbl.push_back(mkv(0,0,0, 1,0,0,3,1,0, 0,0, 1,1,0,1,1,0,5));
        tbl.push_back(mkv(0,1,0, 0,0,0,0,0,0, 0,0, 1,0,0,1,1,0,5));
        for (int k = 0; k < DRAIN_MAX; k++)
            tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,3,1,0,5));
        tbl.push_back(mkv(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,0,0,1,5));
        tbl.push_back(mkv(1,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,0,0,1,5));
        tbl.push_back(mkv(0,0,0, 1,3,0,2,1,0, 0,0, 1,1,0,1,1,1,5));

        drive(z);
        i_reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        #1 check("reset", sample(), zo);

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            #1 check($sformatf("vec%0d", i), sample(), tbl[i].exp);
            @(negedge clk);
        end

        // Reset while running and issuing a write to r6
        x = z; x.dv = 1; x.d = 6; x.wr = 1;
        drive(x);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        #1 check("rst_mid", sample(), zo);
        drive(mkv(1,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,0,0,0,0).in);
        @(negedge clk);
        drive(mkv(0,0,0, 1,2,6,9,1,0, 0,0, 0,0,0,0,0,0,0).in);
        #1 check("rst_pend", sample(), mkv(0,0,0,0,0,0,0,0,0,0,0, 1,1,0,1,1,0,0).exp);
        @(negedge clk);

        // Randomized run against the reference model
        drive(z);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        model_step(z, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            x   = rand_in();
            rst = ($urandom_range(299) == 0);
            drive(x);
            i_reset = rst;
            #1 check($sformatf("rand%0d", n), sample(), model_out(x));
            model_step(x, rst);
            @(negedge clk);
        end
        i_reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
